redas_pe_flex: RTL and testbench

Parametrised successor of the ReDAS roundabout processing element.
- Generalises operand width and accumulator width independently.
- Adds handshaked runtime reconfiguration of dataflow mode and flow direction, valid-tagged links and optional saturating arithmetic.
- Adds an explicit flush state machine that drains the output-stationary accumulator.
- Tiles into roundabout systolic arrays; neighbours connect port-to-port.

---
 rtl/redas_pe_flex_pkg.sv | 45 ++++
 rtl/redas_pe_flex_mac.sv | 33 +++
 rtl/redas_pe_flex.sv | 182 ++++++++++++++++++
 tb/tb_redas_pe_flex.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/redas_pe_flex_pkg.sv
// Shared types and helpers for the ReDAS roundabout processing element.
// Mode encoding matches the original PE so existing configuration tables still apply.
package redas_pe_flex_pkg;

    typedef enum logic [1:0] {
        MODE_WEIGHT = 2'd0,
        MODE_OUTPUT = 2'd1,
        MODE_INPUT  = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam int SAT_W = 64;

    // Adds two sign-extended w-bit values held in SAT_W bits; returns {overflow, result}.
    function automatic logic [SAT_W:0] sat_add(
        input logic signed [SAT_W-1:0] x,
        input logic signed [SAT_W-1:0] y,
        input int                      w,
        input logic                    sat
    );
        logic signed [SAT_W-1:0] s;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] r;
        logic                    ovf;
        s   = x + y;
        hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (w - 1));
        ovf = (s > hi) || (s < lo);
        if (!ovf) begin
            r = s;
        end else if (sat) begin
            r = (s > hi) ? hi : lo;
        end else begin
            r = (s <<< (SAT_W - w)) >>> (SAT_W - w);
        end
        return {ovf, r};
    endfunction

endpackage

// File: rtl/redas_pe_flex_mac.sv
// Combinational a*b + c with saturation or wrap; overflow is reported either way.
module redas_pe_flex_mac
    import redas_pe_flex_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20,
    parameter int SATURATE   = 1
) (
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    input  logic signed [ACC_WIDTH-1:0]  c_i,
    output logic signed [ACC_WIDTH-1:0]  y_o,
    output logic                         ovf_o
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [SAT_W-1:0]        prod_x;
    logic signed [SAT_W-1:0]        c_x;
    logic        [SAT_W:0]          res;
    logic                           unused_res_hi;

    always_comb begin
        prod   = a_i * b_i;
        prod_x = {{(SAT_W-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
        c_x    = {{(SAT_W-ACC_WIDTH){c_i[ACC_WIDTH-1]}}, c_i};
        res    = sat_add(prod_x, c_x, ACC_WIDTH, SATURATE != 0);
        y_o    = res[ACC_WIDTH-1:0];
        ovf_o  = res[SAT_W];
    end

    assign unused_res_hi = ^res[SAT_W-1:ACC_WIDTH];

endmodule

// File: rtl/redas_pe_flex.sv
// Roundabout PE: runtime-configurable dataflow mode and flow direction, valid-tagged
// links, and a flush sequence that drains the output-stationary accumulator.
module redas_pe_flex
    import redas_pe_flex_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20,
    parameter int SATURATE   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ACC_WIDTH-1:0]  in_west,
    input  logic [ACC_WIDTH-1:0]  in_east,
    input  logic [ACC_WIDTH-1:0]  in_north,
    input  logic [ACC_WIDTH-1:0]  in_south,
    input  logic                  in_west_valid,
    input  logic                  in_east_valid,
    input  logic                  in_north_valid,
    input  logic                  in_south_valid,
    output logic [ACC_WIDTH-1:0]  out_west,
    output logic [ACC_WIDTH-1:0]  out_east,
    output logic [ACC_WIDTH-1:0]  out_north,
    output logic [ACC_WIDTH-1:0]  out_south,
    output logic                  out_west_valid,
    output logic                  out_east_valid,
    output logic                  out_north_valid,
    output logic                  out_south_valid,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [1:0]            cfg_mode,
    input  logic                  cfg_h_dir,
    input  logic                  cfg_v_dir,
    input  logic                  stat_we,
    input  logic [DATA_WIDTH-1:0] stat_wdata,
    input  logic                  flush,
    output logic                  sat_flag,
    output logic                  err_misalign,
    output logic [1:0]            dbg_state_o
);

    if (ACC_WIDTH < 2*DATA_WIDTH || ACC_WIDTH >= SAT_W) begin : g_bad_width
        $error("redas_pe_flex: ACC_WIDTH must be >= 2*DATA_WIDTH and < %0d", SAT_W);
    end

    state_e                        state_q, state_d;
    mode_e                         mode_q, mode_d;
    logic                          h_dir_q, h_dir_d, v_dir_q, v_dir_d;
    logic signed [DATA_WIDTH-1:0]  stat_q, stat_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [ACC_WIDTH-1:0]          h_data_q, h_data_d, v_data_q, v_data_d;
    logic                          h_vld_q, h_vld_d, v_vld_q, v_vld_d;
    logic                          sat_q, sat_d, mis_q, mis_d;

    logic [ACC_WIDTH-1:0]          h_src, v_src;
    logic                          h_src_vld, v_src_vld, fire, out_mode;
    logic signed [DATA_WIDTH-1:0]  mac_b;
    logic signed [ACC_WIDTH-1:0]   mac_c, mac_y;
    logic                          mac_ovf;

    assign h_src     = h_dir_q ? in_east : in_west;
    assign h_src_vld = h_dir_q ? in_east_valid : in_west_valid;
    assign v_src     = v_dir_q ? in_south : in_north;
    assign v_src_vld = v_dir_q ? in_south_valid : in_north_valid;
    assign fire      = (state_q == ST_RUN) && h_src_vld && v_src_vld;
    assign out_mode  = (mode_q == MODE_OUTPUT);

    // One MAC serves both paths: psum = V + a*stat, or acc = acc + a*b.
    assign mac_b = out_mode ? v_src[DATA_WIDTH-1:0] : stat_q;
    assign mac_c = out_mode ? acc_q : v_src;

    redas_pe_flex_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .SATURATE   (SATURATE)
    ) u_mac (
        .a_i   (h_src[DATA_WIDTH-1:0]),
        .b_i   (mac_b),
        .c_i   (mac_c),
        .y_o   (mac_y),
        .ovf_o (mac_ovf)
    );

    // Config handshake: a request is accepted on any edge where cfg_valid && cfg_ready.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        h_dir_d  = h_dir_q;
        v_dir_d  = v_dir_q;
        stat_d   = stat_q;
        acc_d    = acc_q;
        h_data_d = h_data_q;
        v_data_d = v_data_q;
        h_vld_d  = 1'b0;
        v_vld_d  = 1'b0;
        sat_d    = sat_q;
        mis_d    = mis_q;
        case (state_q)
            ST_IDLE: begin
                if (stat_we) stat_d = stat_wdata;
                if (cfg_valid) begin
                    mode_d  = (cfg_mode == 2'd3) ? MODE_WEIGHT : mode_e'(cfg_mode);
                    h_dir_d = cfg_h_dir;
                    v_dir_d = cfg_v_dir;
                    acc_d   = '0;
                    sat_d   = 1'b0;
                    mis_d   = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (fire) begin
                    h_data_d = h_src;
                    h_vld_d  = 1'b1;
                    v_vld_d  = 1'b1;
                    if (out_mode) begin
                        v_data_d = v_src;
                        acc_d    = mac_y;
                    end else begin
                        v_data_d = mac_y;
                    end
                    if (mac_ovf) sat_d = 1'b1;
                end
                if (h_src_vld != v_src_vld) mis_d = 1'b1;
                if (flush) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (out_mode) begin
                    v_data_d = acc_q;
                    v_vld_d  = 1'b1;
                    acc_d    = '0;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_WEIGHT;
            h_dir_q  <= 1'b0;
            v_dir_q  <= 1'b0;
            stat_q   <= '0;
            acc_q    <= '0;
            h_data_q <= '0;
            v_data_q <= '0;
            h_vld_q  <= 1'b0;
            v_vld_q  <= 1'b0;
            sat_q    <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            h_dir_q  <= h_dir_d;
            v_dir_q  <= v_dir_d;
            stat_q   <= stat_d;
            acc_q    <= acc_d;
            h_data_q <= h_data_d;
            v_data_q <= v_data_d;
            h_vld_q  <= h_vld_d;
            v_vld_q  <= v_vld_d;
            sat_q    <= sat_d;
            mis_q    <= mis_d;
        end
    end

    assign out_east        = h_dir_q ? '0 : h_data_q;
    assign out_east_valid  = !h_dir_q && h_vld_q;
    assign out_west        = h_dir_q ? h_data_q : '0;
    assign out_west_valid  = h_dir_q && h_vld_q;
    assign out_south       = v_dir_q ? '0 : v_data_q;
    assign out_south_valid = !v_dir_q && v_vld_q;
    assign out_north       = v_dir_q ? v_data_q : '0;
    assign out_north_valid = v_dir_q && v_vld_q;

    assign cfg_ready    = (state_q == ST_IDLE);
    assign sat_flag     = sat_q;
    assign err_misalign = mis_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_redas_pe_flex.sv
// Bench for redas_pe_flex: three instances (20-bit saturating, 16-bit saturating,
// 16-bit wrapping) checked every cycle against a behavioural model plus literal checks.
module tb_redas_pe_flex;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [19:0] a_w, a_e, a_n, a_s;
    logic [15:0] b_w, b_e, b_n, b_s;
    logic        v_w, v_e, v_n, v_s;
    logic        cfg_valid, cfg_h_dir, cfg_v_dir, stat_we, flush;
    logic [1:0]  cfg_mode;
    logic [7:0]  stat_wdata;
    bit          cur_hd, cur_vd, chk_en;

    logic [19:0] o_w[3], o_e[3], o_n[3], o_s[3];
    logic        ov_w[3], ov_e[3], ov_n[3], ov_s[3];
    logic        rdy[3], satf[3], misf[3];
    logic [1:0]  dbg[3];
    logic [15:0] w1_w, w1_e, w1_n, w1_s, w2_w, w2_e, w2_n, w2_s;

    int total = 0;
    int bad   = 0;

    redas_pe_flex #(.DATA_WIDTH(8), .ACC_WIDTH(20), .SATURATE(1)) u0 (
        .clk(clk), .rst_n(rst_n),
        .in_west(a_w), .in_east(a_e), .in_north(a_n), .in_south(a_s),
        .in_west_valid(v_w), .in_east_valid(v_e), .in_north_valid(v_n), .in_south_valid(v_s),
        .out_west(o_w[0]), .out_east(o_e[0]), .out_north(o_n[0]), .out_south(o_s[0]),
        .out_west_valid(ov_w[0]), .out_east_valid(ov_e[0]),
        .out_north_valid(ov_n[0]), .out_south_valid(ov_s[0]),
        .cfg_valid(cfg_valid), .cfg_ready(rdy[0]), .cfg_mode(cfg_mode),
        .cfg_h_dir(cfg_h_dir), .cfg_v_dir(cfg_v_dir),
        .stat_we(stat_we), .stat_wdata(stat_wdata), .flush(flush),
        .sat_flag(satf[0]), .err_misalign(misf[0]), .dbg_state_o(dbg[0])
    );

    redas_pe_flex #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SATURATE(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_west(b_w), .in_east(b_e), .in_north(b_n), .in_south(b_s),
        .in_west_valid(v_w), .in_east_valid(v_e), .in_north_valid(v_n), .in_south_valid(v_s),
        .out_west(w1_w), .out_east(w1_e), .out_north(w1_n), .out_south(w1_s),
        .out_west_valid(ov_w[1]), .out_east_valid(ov_e[1]),
        .out_north_valid(ov_n[1]), .out_south_valid(ov_s[1]),
        .cfg_valid(cfg_valid), .cfg_ready(rdy[1]), .cfg_mode(cfg_mode),
        .cfg_h_dir(cfg_h_dir), .cfg_v_dir(cfg_v_dir),
        .stat_we(stat_we), .stat_wdata(stat_wdata), .flush(flush),
        .sat_flag(satf[1]), .err_misalign(misf[1]), .dbg_state_o(dbg[1])
    );

    redas_pe_flex #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SATURATE(0)) u2 (
        .clk(clk), .rst_n(rst_n),
        .in_west(b_w), .in_east(b_e), .in_north(b_n), .in_south(b_s),
        .in_west_valid(v_w), .in_east_valid(v_e), .in_north_valid(v_n), .in_south_valid(v_s),
        .out_west(w2_w), .out_east(w2_e), .out_north(w2_n), .out_south(w2_s),
        .out_west_valid(ov_w[2]), .out_east_valid(ov_e[2]),
        .out_north_valid(ov_n[2]), .out_south_valid(ov_s[2]),
        .cfg_valid(cfg_valid), .cfg_ready(rdy[2]), .cfg_mode(cfg_mode),
        .cfg_h_dir(cfg_h_dir), .cfg_v_dir(cfg_v_dir),
        .stat_we(stat_we), .stat_wdata(stat_wdata), .flush(flush),
        .sat_flag(satf[2]), .err_misalign(misf[2]), .dbg_state_o(dbg[2])
    );

    assign o_w[1] = {4'b0, w1_w};
    assign o_e[1] = {4'b0, w1_e};
    assign o_n[1] = {4'b0, w1_n};
    assign o_s[1] = {4'b0, w1_s};
    assign o_w[2] = {4'b0, w2_w};
    assign o_e[2] = {4'b0, w2_e};
    assign o_n[2] = {4'b0, w2_n};
    assign o_s[2] = {4'b0, w2_s};

    // ---------------- behavioural model ----------------
    int     W[3] = '{20, 16, 16};
    int     S[3] = '{1, 1, 0};
    int     m_phase, m_mode;       // phase: 0 idle, 1 run, 2 flush
    bit     m_hd, m_vd, m_hv, m_vv, m_mis;
    longint m_stat;
    longint m_acc[3], m_hw[3], m_vw[3];
    bit     m_sat[3];

    function automatic longint sx(input longint v, input int w);
        longint r;
        r = v & ((longint'(1) << w) - 1);
        if (((r >> (w - 1)) & 1) == 1) r = r - (longint'(1) << w);
        return r;
    endfunction

    function automatic longint fit(input longint s, input int w, input int sat, output bit ovf);
        longint hi, lo;
        hi  = (longint'(1) << (w - 1)) - 1;
        lo  = -(longint'(1) << (w - 1));
        ovf = (s > hi) || (s < lo);
        if (!ovf) return s;
        if (sat != 0) return (s > hi) ? hi : lo;
        return sx(s, w);
    endfunction

    function automatic longint src_h(input int k);
        if (k == 0) return m_hd ? longint'(a_e) : longint'(a_w);
        return m_hd ? longint'(b_e) : longint'(b_w);
    endfunction

    function automatic longint src_v(input int k);
        if (k == 0) return m_vd ? longint'(a_s) : longint'(a_n);
        return m_vd ? longint'(b_s) : longint'(b_n);
    endfunction

    always @(posedge clk) begin
        longint h, v, pa;
        bit     hval, vval, fire, o;
        if (!rst_n) begin
            m_phase = 0; m_mode = 0; m_hd = 0; m_vd = 0; m_stat = 0;
            m_hv = 0; m_vv = 0; m_mis = 0;
            for (int k = 0; k < 3; k++) begin
                m_acc[k] = 0; m_hw[k] = 0; m_vw[k] = 0; m_sat[k] = 0;
            end
        end else if (m_phase == 0) begin
            m_hv = 0; m_vv = 0;
            if (stat_we) m_stat = sx(longint'(stat_wdata), 8);
            if (cfg_valid) begin
                m_mode = (cfg_mode == 2'd3) ? 0 : int'(cfg_mode);
                m_hd = cfg_h_dir; m_vd = cfg_v_dir; m_mis = 0;
                for (int k = 0; k < 3; k++) begin
                    m_acc[k] = 0; m_sat[k] = 0;
                end
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            hval = m_hd ? v_e : v_w;
            vval = m_vd ? v_s : v_n;
            fire = hval && vval;
            if (hval != vval) m_mis = 1;
            if (fire) begin
                for (int k = 0; k < 3; k++) begin
                    h = src_h(k); v = src_v(k); pa = sx(h, 8);
                    m_hw[k] = h;
                    if (m_mode == 1) begin
                        m_vw[k]  = v;
                        m_acc[k] = fit(m_acc[k] + pa * sx(v, 8), W[k], S[k], o);
                    end else begin
                        m_vw[k] = fit(sx(v, W[k]) + pa * m_stat, W[k], S[k], o);
                    end
                    if (o) m_sat[k] = 1;
                end
            end
            m_hv = fire; m_vv = fire;
            if (flush) m_phase = 2;
        end else begin
            m_hv = 0;
            m_vv = (m_mode == 1);
            if (m_mode == 1) begin
                for (int k = 0; k < 3; k++) begin
                    m_vw[k] = m_acc[k]; m_acc[k] = 0;
                end
            end
            m_phase = 0;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                longint mk;
                mk = (longint'(1) << W[k]) - 1;
                chk($sformatf("i%0d_east", k),    o_e[k],  m_hd ? 0 : (m_hw[k] & mk));
                chk($sformatf("i%0d_west", k),    o_w[k],  m_hd ? (m_hw[k] & mk) : 0);
                chk($sformatf("i%0d_south", k),   o_s[k],  m_vd ? 0 : (m_vw[k] & mk));
                chk($sformatf("i%0d_north", k),   o_n[k],  m_vd ? (m_vw[k] & mk) : 0);
                chk($sformatf("i%0d_east_v", k),  ov_e[k], !m_hd && m_hv);
                chk($sformatf("i%0d_west_v", k),  ov_w[k], m_hd && m_hv);
                chk($sformatf("i%0d_south_v", k), ov_s[k], !m_vd && m_vv);
                chk($sformatf("i%0d_north_v", k), ov_n[k], m_vd && m_vv);
                chk($sformatf("i%0d_ready", k),   rdy[k],  m_phase == 0);
                chk($sformatf("i%0d_sat", k),     satf[k], m_sat[k]);
                chk($sformatf("i%0d_mis", k),     misf[k], m_mis);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet();
        v_w = 0; v_e = 0; v_n = 0; v_s = 0;
    endtask

    task automatic do_cfg(input int mode, input bit hd, input bit vd);
        cfg_valid = 1; cfg_mode = 2'(mode); cfg_h_dir = hd; cfg_v_dir = vd;
        cur_hd = hd; cur_vd = vd;
        tick();
        cfg_valid = 0; stat_we = 0;
    endtask

    task automatic drive_pair(input logic [19:0] h0, input logic [19:0] v0,
                              input logic [15:0] h1, input logic [15:0] v1,
                              input bit hv, input bit vv);
        a_w = 20'($urandom); a_e = 20'($urandom); a_n = 20'($urandom); a_s = 20'($urandom);
        b_w = 16'($urandom); b_e = 16'($urandom); b_n = 16'($urandom); b_s = 16'($urandom);
        v_w = 1'($urandom_range(0, 1)); v_e = 1'($urandom_range(0, 1));
        v_n = 1'($urandom_range(0, 1)); v_s = 1'($urandom_range(0, 1));
        if (!cur_hd) begin a_w = h0; b_w = h1; v_w = hv; end
        else         begin a_e = h0; b_e = h1; v_e = hv; end
        if (!cur_vd) begin a_n = v0; b_n = v1; v_n = vv; end
        else         begin a_s = v0; b_s = v1; v_s = vv; end
    endtask

    task automatic drain();
        flush = 1; tick(); flush = 0; tick();
    endtask

    initial begin
        rst_n = 0; cfg_valid = 0; cfg_mode = 0; cfg_h_dir = 0; cfg_v_dir = 0;
        stat_we = 0; stat_wdata = 0; flush = 0; chk_en = 0; cur_hd = 0; cur_vd = 0;
        a_w = 0; a_e = 0; a_n = 0; a_s = 0; b_w = 0; b_e = 0; b_n = 0; b_s = 0;
        quiet();
        tick(); tick();
        chk_en = 1;
        chk("rst_ready", rdy[0], 1);
        chk("rst_south", o_s[0], 0);
        chk("rst_east_v", ov_e[0], 0);
        rst_n = 1;

        // weight mode, stationary 3: 5 * 3 + 100
        stat_we = 1; stat_wdata = 8'd3; do_cfg(0, 0, 0);
        drive_pair(20'd5, 20'd100, 16'd5, 16'd100, 1, 1); tick(); quiet();
        chk("t1_east", o_e[0], 5);
        chk("t1_south", o_s[0], 115);
        chk("t1_east_v", ov_e[0], 1);
        chk("t1_south_v", ov_s[0], 1);
        chk("t1_west_v", ov_w[0], 0);
        chk("t1_north_v", ov_n[0], 0);

        // lone H valid
        drive_pair(20'd7, 20'd0, 16'd7, 16'd0, 1, 0); tick(); quiet();
        chk("t5_south_v", ov_s[0], 0);
        chk("t5_mis", misf[0], 1);
        tick();
        chk("t5_mis_hold", misf[0], 1);
        drain();
        chk("t5_mis_idle", misf[0], 1);

        // output stationary: 2*3 - 4*5 + 7*7 = 35
        do_cfg(1, 0, 0);
        chk("t5_mis_clr", misf[0], 0);
        drive_pair(20'd2, 20'd3, 16'd2, 16'd3, 1, 1); tick();
        drive_pair(20'hFFFFC, 20'd5, 16'hFFFC, 16'd5, 1, 1); tick();
        drive_pair(20'd7, 20'd7, 16'd7, 16'd7, 1, 1); tick(); quiet();
        flush = 1; tick(); flush = 0;
        chk("t2_pre_v", ov_s[0], 0);
        tick();
        chk("t2_word", o_s[0], 35);
        chk("t2_word_v", ov_s[0], 1);
        chk("t2_ready", rdy[0], 1);

        // saturate vs wrap at 16 bits
        stat_we = 1; stat_wdata = 8'd127; do_cfg(0, 0, 0);
        drive_pair(20'd127, 20'd32767, 16'd127, 16'h7FFF, 1, 1); tick(); quiet();
        chk("t3_sat_south", o_s[1], 20'h07FFF);
        chk("t3_sat_flag", satf[1], 1);
        chk("t3_wrap_south", o_s[2], 20'h0BF00);
        chk("t3_wrap_flag", satf[2], 1);
        chk("t3_wide_south", o_s[0], 48896);
        chk("t3_wide_flag", satf[0], 0);
        drain();

        // reversed flow: east->west, south->north
        stat_we = 1; stat_wdata = 8'd2; do_cfg(0, 1, 1);
        drive_pair(20'd10, 20'd7, 16'd10, 16'd7, 1, 1); tick(); quiet();
        chk("t4_west", o_w[0], 10);
        chk("t4_north", o_n[0], 27);
        chk("t4_west_v", ov_w[0], 1);
        chk("t4_north_v", ov_n[0], 1);
        chk("t4_east_v", ov_e[0], 0);
        chk("t4_south_v", ov_s[0], 0);
        chk("t4_east", o_e[0], 0);
        drain();

        // reset mid-run with acc = 35
        do_cfg(1, 0, 0);
        drive_pair(20'd2, 20'd3, 16'd2, 16'd3, 1, 1); tick();
        drive_pair(20'hFFFFC, 20'd5, 16'hFFFC, 16'd5, 1, 1); tick();
        drive_pair(20'd7, 20'd7, 16'd7, 16'd7, 1, 1); tick(); quiet();
        rst_n = 0; tick(); rst_n = 1;
        chk("t6_ready", rdy[0], 1);
        chk("t6_south", o_s[0], 0);
        chk("t6_east", o_e[0], 0);
        chk("t6_south_v", ov_s[0], 0);
        flush = 1; tick(); flush = 0; tick();
        chk("t6_noword_v", ov_s[0], 0);
        chk("t6_noword", o_s[0], 0);

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            int n;
            n = int'($urandom_range(3, 25));
            stat_we = 1'($urandom_range(0, 1)); stat_wdata = 8'($urandom);
            do_cfg(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int c = 0; c < n; c++) begin
                int r;
                r = int'($urandom_range(0, 9));
                drive_pair(20'($urandom), 20'($urandom), 16'($urandom), 16'($urandom),
                           (r < 9), (r < 8) || (r == 9));
                cfg_valid  = ($urandom_range(0, 7) == 0);
                stat_we    = ($urandom_range(0, 7) == 0);
                stat_wdata = 8'($urandom);
                flush      = (c == n - 1);
                if (c == n - 2 && $urandom_range(0, 9) == 0) rst_n = 0;
                tick();
                rst_n = 1;
            end
            flush = 0; cfg_valid = 0; stat_we = 0;
            drive_pair(20'($urandom), 20'($urandom), 16'($urandom), 16'($urandom), 1, 1);
            tick();
            drive_pair(20'($urandom), 20'($urandom), 16'($urandom), 16'($urandom), 1, 1);
            tick();
            quiet();
        end

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
